// File: rtl/ysyx_axi_pkg.sv
// Shared AXI encodings, slave FSM states and address-stepping helpers
// for the on-chip SRAM responder.
package ysyx_axi_pkg;

   localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RD    = 2'd1,
      WR    = 2'd2,
      BRESP = 2'd3
   } axi_slv_state_e;

   // FIXED holds the address; every other burst type steps like INCR (non-INCR beats are errors anyway)
   function automatic logic [31:0] axi_next_addr(input logic [31:0] addr,
                                                 input logic [2:0]  size,
                                                 input logic [1:0]  burst);
      logic [31:0] next_s;
      if (burst == AXI_BURST_FIXED) begin
         next_s = addr;
      end else begin
         next_s = addr + (32'd1 << size);
      end
      return next_s;
   endfunction

   // Response codes are ordered so that the numerically larger one is the worse one
   function automatic logic [1:0] axi_worst_resp(input logic [1:0] a, input logic [1:0] b);
      logic [1:0] w_s;
      if (a > b) begin
         w_s = a;
      end else begin
         w_s = b;
      end
      return w_s;
   endfunction

endpackage

// File: rtl/ysyx_axi_slv_mem.sv
// Word SRAM for the AXI slave: combinational read, byte-masked write, no reset.
module ysyx_axi_slv_mem
   import ysyx_axi_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int MEM_WORDS = 1024,
   parameter int AW        = $clog2(MEM_WORDS)
) (
   input  logic            clock,
   input  logic            we,
   input  logic [3:0]      wstrb,
   input  logic [AW-1:0]   addr,
   input  logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] rdata
);

   logic [XLEN-1:0] mem_r [MEM_WORDS];

   assign rdata = mem_r[addr];

   // Byte-lane write; array contents survive reset
   always_ff @(posedge clock) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
               mem_r[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/ysyx_axi_slv_sram.sv
// AXI4 slave that terminates one read or write burst at a time into an on-chip
// word SRAM, with round-robin arbitration between AR and AW.
module ysyx_axi_slv_sram
   import ysyx_axi_pkg::*;
#(
   parameter int          XLEN      = 32,
   parameter logic [31:0] ADDR_BASE = 32'h0f00_0000,
   parameter int          MEM_WORDS = 1024
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [1:0]      axi_arburst,
   input  logic [2:0]      axi_arsize,
   input  logic [7:0]      axi_arlen,
   input  logic [3:0]      axi_arid,
   input  logic [XLEN-1:0] axi_araddr,
   input  logic            axi_arvalid,
   output logic            axi_arready,
   output logic [3:0]      axi_rid,
   output logic            axi_rlast,
   output logic [XLEN-1:0] axi_rdata,
   output logic [1:0]      axi_rresp,
   output logic            axi_rvalid,
   input  logic            axi_rready,
   input  logic [1:0]      axi_awburst,
   input  logic [2:0]      axi_awsize,
   input  logic [7:0]      axi_awlen,
   input  logic [3:0]      axi_awid,
   input  logic [XLEN-1:0] axi_awaddr,
   input  logic            axi_awvalid,
   output logic            axi_awready,
   input  logic            axi_wlast,
   input  logic [XLEN-1:0] axi_wdata,
   input  logic [3:0]      axi_wstrb,
   input  logic            axi_wvalid,
   output logic            axi_wready,
   output logic [3:0]      axi_bid,
   output logic [1:0]      axi_bresp,
   output logic            axi_bvalid,
   input  logic            axi_bready
);

   localparam int              AW   = $clog2(MEM_WORDS);
   localparam logic [XLEN-1:0] SPAN = XLEN'(4 * MEM_WORDS);

   function automatic logic [1:0] beat_resp(input logic [XLEN-1:0] addr,
                                            input logic [2:0]      size,
                                            input logic [1:0]      burst);
      logic [1:0] r_s;
      if ((addr - ADDR_BASE) >= SPAN) begin
         r_s = AXI_RESP_DECERR;
      end else if (size > 3'd2 || burst == AXI_BURST_WRAP || burst == 2'b11) begin
         r_s = AXI_RESP_SLVERR;
      end else begin
         r_s = AXI_RESP_OKAY;
      end
      return r_s;
   endfunction

   axi_slv_state_e  state_r;
   logic            rr_r;
   logic [7:0]      len_r, beat_cnt_r;
   logic [2:0]      size_r;
   logic [1:0]      burst_r, rresp_r, bresp_r, wresp_r;
   logic [XLEN-1:0] addr_r, rdata_r;
   logic [3:0]      rid_r, bid_r;
   logic            rlast_r, rvalid_r, bvalid_r;

   logic            ar_grant_s, aw_grant_s, r_hs_s, w_hs_s, w_last_s, mem_we_s;
   logic [XLEN-1:0] next_addr_s, beat_addr_s, mem_rdata_s;
   logic [2:0]      beat_size_s;
   logic [1:0]      beat_burst_s, beat_resp_s, w_resp_s;
   logic [AW-1:0]   mem_word_s;

   assign ar_grant_s  = ~reset & (state_r == IDLE) & axi_arvalid & (~axi_awvalid | rr_r);
   assign aw_grant_s  = ~reset & (state_r == IDLE) & axi_awvalid & (~axi_arvalid | ~rr_r);
   assign r_hs_s      = rvalid_r & axi_rready;
   assign w_hs_s      = (state_r == WR) & axi_wvalid;
   assign w_last_s    = (beat_cnt_r == len_r);
   assign next_addr_s = axi_next_addr(addr_r, size_r, burst_r);

   // Pick the beat the single SRAM port serves: AR beat 0 in IDLE, the following beat in RD
   always_comb begin
      beat_addr_s  = addr_r;
      beat_size_s  = size_r;
      beat_burst_s = burst_r;
      case (state_r)
         IDLE: begin
            beat_addr_s  = axi_araddr;
            beat_size_s  = axi_arsize;
            beat_burst_s = axi_arburst;
         end
         RD:      beat_addr_s = next_addr_s;
         default: beat_addr_s = addr_r;
      endcase
   end

   assign beat_resp_s = beat_resp(beat_addr_s, beat_size_s, beat_burst_s);
   assign mem_word_s  = AW'((beat_addr_s - ADDR_BASE) >> 2);
   assign w_resp_s    = (axi_wlast != w_last_s) ? axi_worst_resp(beat_resp_s, AXI_RESP_SLVERR)
                                                : beat_resp_s;
   assign mem_we_s    = w_hs_s & (beat_resp_s == AXI_RESP_OKAY);

   ysyx_axi_slv_mem #(.XLEN(XLEN), .MEM_WORDS(MEM_WORDS), .AW(AW)) u_mem (
      .clock (clock),
      .we    (mem_we_s),
      .wstrb (axi_wstrb),
      .addr  (mem_word_s),
      .wdata (axi_wdata),
      .rdata (mem_rdata_s)
   );

   // Transaction FSM with registered R/B channel outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r    <= IDLE;
         rr_r       <= 1'b0;
         len_r      <= 8'd0;
         beat_cnt_r <= 8'd0;
         size_r     <= 3'd0;
         burst_r    <= 2'd0;
         addr_r     <= '0;
         rdata_r    <= '0;
         rresp_r    <= 2'd0;
         rid_r      <= 4'd0;
         rlast_r    <= 1'b0;
         rvalid_r   <= 1'b0;
         bid_r      <= 4'd0;
         bresp_r    <= 2'd0;
         wresp_r    <= 2'd0;
         bvalid_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (ar_grant_s) begin
                  rid_r      <= axi_arid;
                  len_r      <= axi_arlen;
                  size_r     <= axi_arsize;
                  burst_r    <= axi_arburst;
                  addr_r     <= axi_araddr;
                  beat_cnt_r <= 8'd0;
                  rdata_r    <= (beat_resp_s == AXI_RESP_OKAY) ? mem_rdata_s : '0;
                  rresp_r    <= beat_resp_s;
                  rlast_r    <= (axi_arlen == 8'd0);
                  rvalid_r   <= 1'b1;
                  state_r    <= RD;
                  if (axi_awvalid) rr_r <= ~rr_r;
               end else if (aw_grant_s) begin
                  bid_r      <= axi_awid;
                  len_r      <= axi_awlen;
                  size_r     <= axi_awsize;
                  burst_r    <= axi_awburst;
                  addr_r     <= axi_awaddr;
                  beat_cnt_r <= 8'd0;
                  wresp_r    <= AXI_RESP_OKAY;
                  state_r    <= WR;
                  if (axi_arvalid) rr_r <= ~rr_r;
               end
            end
            RD: begin
               if (r_hs_s) begin
                  if (rlast_r) begin
                     rvalid_r <= 1'b0;
                     state_r  <= IDLE;
                  end else begin
                     addr_r     <= next_addr_s;
                     beat_cnt_r <= beat_cnt_r + 8'd1;
                     rdata_r    <= (beat_resp_s == AXI_RESP_OKAY) ? mem_rdata_s : '0;
                     rresp_r    <= beat_resp_s;
                     rlast_r    <= ((beat_cnt_r + 8'd1) == len_r);
                  end
               end
            end
            WR: begin
               if (w_hs_s) begin
                  if (w_last_s) begin
                     bresp_r  <= axi_worst_resp(wresp_r, w_resp_s);
                     bvalid_r <= 1'b1;
                     state_r  <= BRESP;
                  end else begin
                     wresp_r    <= axi_worst_resp(wresp_r, w_resp_s);
                     addr_r     <= next_addr_s;
                     beat_cnt_r <= beat_cnt_r + 8'd1;
                  end
               end
            end
            BRESP: begin
               if (axi_bready) begin
                  bvalid_r <= 1'b0;
                  state_r  <= IDLE;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   assign axi_arready = ar_grant_s;
   assign axi_awready = aw_grant_s;
   assign axi_wready  = (state_r == WR);
   assign axi_rid     = rid_r;
   assign axi_rlast   = rlast_r;
   assign axi_rdata   = rdata_r;
   assign axi_rresp   = rresp_r;
   assign axi_rvalid  = rvalid_r;
   assign axi_bid     = bid_r;
   assign axi_bresp   = bresp_r;
   assign axi_bvalid  = bvalid_r;

endmodule
